// File: rtl/ta_adc_pkg.sv
// ta_adc_pkg: shared state encoding, lane count and default widths for the ADC capture controller.
package ta_adc_pkg;
  localparam int SAMPLES     = 4;
  localparam int ADC_W_DEF   = 14;
  localparam int WORD_W_DEF  = SAMPLES * ADC_W_DEF;
  localparam int LEN_W_DEF   = 16;
  localparam int DISCARD_DEF = 2;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, CAPTURE, DONE} state_t;
endpackage

// File: rtl/ta_adc_trig_cmp.sv
// ta_adc_trig_cmp: flags a merged word when any of its unsigned samples reaches the trigger level.
module ta_adc_trig_cmp import ta_adc_pkg::*; #(
  parameter int W = ADC_W_DEF
) (
  input  logic [SAMPLES*W-1:0] data_i,
  input  logic [W-1:0]         level_i,
  output logic                 hit_o
);
  logic [SAMPLES-1:0] ge;
  for (genvar k = 0; k < SAMPLES; k++) begin : g_lane
    assign ge[k] = data_i[k*W +: W] >= level_i;
  end
  assign hit_o = |ge;
endmodule

// File: rtl/ta_adc_cap_ctrl.sv
// ta_adc_cap_ctrl: arms, flushes, triggers and streams a fixed-length burst of merged ADC words.
module ta_adc_cap_ctrl import ta_adc_pkg::*; #(
  parameter int ADC0_0  = ADC_W_DEF,
  parameter int ADC0_1  = WORD_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int DISCARD = DISCARD_DEF
) (
  input  logic              clk62,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              trig_mode,
  input  logic              sw_trig,
  input  logic [ADC0_0-1:0] trig_level,
  input  logic [LEN_W-1:0]  cap_len,
  input  logic [ADC0_1-1:0] merge_data,
  input  logic              mereg_datv,
  output logic              merge_en,
  output logic [ADC0_1-1:0] cap_data,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic              cap_last,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  localparam int DW = $clog2(DISCARD + 2);
  state_t            state_q;
  logic [LEN_W-1:0]  len_q, cnt_q, cnt_d;
  logic [DW-1:0]     disc_q;
  logic              seen_q, hit, trig, accept;
  logic [ADC0_1-1:0] cap_data_q;
  logic              cap_valid_q, cap_last_q, merge_en_q, busy_q, done_q, overflow_q;
  ta_adc_trig_cmp #(.W(ADC0_0)) u_cmp (
    .data_i (merge_data[SAMPLES*ADC0_0-1:0]),
    .level_i(trig_level),
    .hit_o  (hit)
  );
  assign cnt_d  = cnt_q + LEN_W'(1);
  assign trig   = mereg_datv && (trig_mode ? hit : (sw_trig || seen_q));
  assign accept = cap_valid_q && cap_ready;
  always_ff @(posedge clk62 or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      disc_q      <= '0;
      seen_q      <= 1'b0;
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
      cap_last_q  <= 1'b0;
      merge_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q     <= IDLE;
        cap_valid_q <= 1'b0;
        cap_last_q  <= 1'b0;
        merge_en_q  <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start && cap_len != '0) begin
            state_q    <= (DISCARD == 0) ? WAIT_TRIG : ARM;
            len_q      <= cap_len;
            cnt_q      <= '0;
            disc_q     <= '0;
            seen_q     <= 1'b0;
            overflow_q <= 1'b0;
            merge_en_q <= 1'b1;
            busy_q     <= 1'b1;
          end
          ARM: if (mereg_datv) begin
            disc_q <= disc_q + DW'(1);
            if (disc_q == DW'(DISCARD - 1)) state_q <= WAIT_TRIG;
          end
          WAIT_TRIG: begin
            seen_q <= seen_q | sw_trig;
            if (trig) begin
              state_q     <= CAPTURE;
              cap_data_q  <= merge_data;
              cap_valid_q <= 1'b1;
              cap_last_q  <= len_q == LEN_W'(1);
              cnt_q       <= LEN_W'(1);
            end
          end
          CAPTURE: if (accept && cap_last_q) begin
            state_q     <= DONE;
            cap_valid_q <= 1'b0;
            cap_last_q  <= 1'b0;
            merge_en_q  <= 1'b0;
            done_q      <= 1'b1;
          end else if (mereg_datv && cnt_q != len_q) begin
            // a full, unaccepted output register drops the word without counting it
            if (!cap_valid_q || accept) begin
              cap_data_q  <= merge_data;
              cap_valid_q <= 1'b1;
              cap_last_q  <= cnt_d == len_q;
              cnt_q       <= cnt_d;
            end else begin
              overflow_q <= 1'b1;
            end
          end else if (accept) begin
            cap_valid_q <= 1'b0;
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign merge_en  = merge_en_q;
  assign cap_data  = cap_data_q;
  assign cap_valid = cap_valid_q;
  assign cap_last  = cap_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_ta_adc_cap_ctrl.sv
// tb_ta_adc_cap_ctrl: scoreboard bench with a cycle-level reference model of the capture controller.
module tb_ta_adc_cap_ctrl;
  localparam int DISCARD = 2;
  logic        clk62 = 1'b0, rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, trig_mode = 1'b0, sw_trig = 1'b0;
  logic [13:0] trig_level = '0;
  logic [15:0] cap_len = '0;
  logic [55:0] merge_data = '0;
  logic        mereg_datv = 1'b0, cap_ready = 1'b0;
  logic        merge_en, cap_valid, cap_last, busy, done, overflow;
  logic [55:0] cap_data;
  ta_adc_cap_ctrl dut (
    .clk62(clk62), .rst(rst), .start(start), .abort(abort), .trig_mode(trig_mode),
    .sw_trig(sw_trig), .trig_level(trig_level), .cap_len(cap_len), .merge_data(merge_data),
    .mereg_datv(mereg_datv), .merge_en(merge_en), .cap_data(cap_data), .cap_valid(cap_valid),
    .cap_ready(cap_ready), .cap_last(cap_last), .busy(busy), .done(done), .overflow(overflow)
  );
  always #5 clk62 = ~clk62;
  int n_cmp = 0, n_bad = 0;
  int ph = 0, m_cnt = 0, m_len = 0, m_disc = 0;
  bit m_full = 0, m_seen = 0, m_ovf = 0, chk_en = 0, got_first = 0;
  logic [5:0]  e_status = '0;
  logic [56:0] expq[$];
  logic [55:0] first_data = '0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    ph = 0; m_full = 0; m_cnt = 0; m_len = 0; m_disc = 0; m_seen = 0; m_ovf = 0;
    expq.delete();
    e_status = '0;
  endtask
  // ph: 0 idle, 1 flushing, 2 waiting for trigger, 3 capturing, 4 done
  task automatic model_step();
    bit acc, hit, trg;
    e_status = {m_full, m_full && m_cnt == m_len, ph != 0, ph inside {1, 2, 3}, ph == 4, m_ovf};
    acc = m_full && cap_ready;
    if (abort) begin
      ph = 0; m_full = 0; expq.delete();
    end else if (ph == 0) begin
      if (start && cap_len != 0) begin
        ph = (DISCARD == 0) ? 2 : 1; m_len = int'(cap_len); m_ovf = 0; m_disc = 0; m_seen = 0; m_cnt = 0;
      end
    end else if (ph == 1) begin
      if (mereg_datv) begin
        m_disc++;
        if (m_disc == DISCARD) ph = 2;
      end
    end else if (ph == 2) begin
      hit = 0;
      for (int k = 0; k < 4; k++) if (merge_data[k*14 +: 14] >= trig_level) hit = 1;
      trg = trig_mode ? hit : (sw_trig || m_seen);
      m_seen = m_seen | sw_trig;
      if (mereg_datv && trg) begin
        expq.push_back({m_len == 1, merge_data}); m_full = 1; m_cnt = 1; ph = 3;
      end
    end else if (ph == 3) begin
      if (acc && m_cnt == m_len) begin
        ph = 4; m_full = 0;
      end else if (mereg_datv && m_cnt < m_len) begin
        if (!m_full || acc) begin
          m_cnt++; expq.push_back({m_cnt == m_len, merge_data}); m_full = 1;
        end else m_ovf = 1;
      end else if (acc) m_full = 0;
    end else ph = 0;
  endtask
  task automatic cyc(input logic st, input logic ab, input logic sw, input logic dv, input logic rdy, input logic [55:0] d);
    @(posedge clk62); #1;
    start = st; abort = ab; sw_trig = sw; mereg_datv = dv; cap_ready = rdy; merge_data = d;
    model_step();
  endtask
  always @(negedge clk62) if (chk_en) begin
    chk("status", {58'd0, cap_valid, cap_last, busy, merge_en, done, overflow}, {58'd0, e_status});
    if (cap_valid && cap_ready && !abort) begin
      if (expq.size() == 0) chk("pop_nonempty", 64'd0, 64'd1);
      else begin
        logic [56:0] e;
        e = expq.pop_front();
        chk("cap_data", {8'd0, cap_data}, {8'd0, e[55:0]});
        chk("cap_last", {63'd0, cap_last}, {63'd0, e[56]});
        if (!got_first) begin first_data = cap_data; got_first = 1; end
      end
    end
  end
  task automatic txn(input int mode, input int len, input logic [13:0] lvl, input int sw_at, input int vp,
                     input int rp, input int rdy_lo, input int abort_at, input int pat,
                     input logic [55:0] exp_first, input int chk_first);
    int wn, c;
    logic dv, sw;
    logic [55:0] d;
    wn = 0; c = 1; got_first = 0;
    trig_mode = mode[0]; trig_level = lvl; cap_len = len[15:0];
    cyc(1, 0, 0, 0, 1, '0);
    while (ph != 0 && c < 3000) begin
      dv = $urandom_range(99) < vp;
      if (dv) wn++;
      d = {$urandom, $urandom};
      if (pat != 0) d = (wn == 7) ? {14'(wn), 14'h2000, 14'(wn), 14'(wn)} : {4{14'(wn)}};
      sw = (sw_at < 0) ? ($urandom_range(9) == 0) : (c == sw_at);
      cyc($urandom_range(99) < 3, c == abort_at, sw, dv, c >= rdy_lo && $urandom_range(99) < rp, d);
      c++;
    end
    if (ph != 0) begin
      chk("txn_timeout", 64'd1, 64'd0);
      cyc(0, 1, 0, 0, 0, '0);
    end
    cyc(0, 0, 0, 0, 1, '0);
    cyc(0, 0, 0, 0, 1, '0);
    if (chk_first != 0) chk("first_word", {8'd0, first_data}, {8'd0, exp_first});
    chk("queue_drained", 64'(expq.size()), 64'd0);
  endtask
  initial begin
    logic [55:0] w7;
    w7 = {14'd7, 14'h2000, 14'd7, 14'd7};
    model_reset();
    repeat (3) @(posedge clk62);
    #2 chk("reset_state", {2'd0, cap_data, cap_valid, cap_last, busy, merge_en, done, overflow}, 64'd0);
    rst = 1'b1;
    chk_en = 1;
    txn(0, 4, 14'd0, 6, 100, 100, 0, 0, 1, {4{14'd6}}, 1);
    txn(1, 4, 14'h2000, 0, 100, 100, 0, 0, 1, w7, 1);
    txn(0, 3, 14'd0, 3, 100, 100, 8, 0, 1, {4{14'd3}}, 1);
    chk("overflow_sticky", {63'd0, overflow}, 64'd1);
    txn(0, 8, 14'd0, 3, 100, 100, 0, 6, 1, {4{14'd3}}, 1);
    chk("abort_idle", {62'd0, busy, cap_valid}, 64'd0);
    cap_len = 16'd0;
    cyc(1, 0, 0, 0, 1, '0);
    cyc(0, 0, 0, 0, 1, '0);
    chk("len0_ignored", {63'd0, busy}, 64'd0);
    cap_len = 16'd4;
    cyc(1, 1, 0, 0, 1, '0);
    cyc(0, 0, 0, 0, 1, '0);
    chk("abort_beats_start", {63'd0, busy}, 64'd0);
    trig_mode = 1'b0; cap_len = 16'd5;
    cyc(1, 0, 0, 0, 1, '0);
    for (int c = 1; c <= 8; c++) cyc(0, 0, c == 3, 1, 0, {$urandom, $urandom});
    chk("pre_reset_busy", {62'd0, busy, cap_valid}, 64'd3);
    chk_en = 0;
    #2 rst = 1'b0;
    #1 chk("async_reset", {2'd0, cap_data, cap_valid, cap_last, busy, merge_en, done, overflow}, 64'd0);
    model_reset();
    start = 0; abort = 0; sw_trig = 0; mereg_datv = 0;
    @(negedge clk62); rst = 1'b1;
    #1 chk_en = 1;
    repeat (40) begin
      int ab;
      ab = ($urandom_range(4) == 0) ? int'($urandom_range(30, 2)) : 0;
      txn($urandom_range(1), $urandom_range(6, 1), 14'($urandom_range(14'h3000)), -1,
          $urandom_range(100, 50), $urandom_range(100, 30), 0, ab, 0, '0, 0);
    end
    cyc(0, 0, 0, 0, 1, '0);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
